// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates instruction fetch and data accesses onto a single
//             word-wide memory port with size/lane handling and misalign check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
  input  logic        clk,
  input  logic        nRst,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic [1:0]  d_fetch,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic [31:0] imemload,
  output logic [31:0] dmmload,
  output logic        i_ready,
  output logic        d_ready,
  output logic        d_err
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_IACC = 2'd1;
  localparam logic [1:0] c_DACC = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [1:0] c_SZ_WORD = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_BYTE = 2'b10;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_wr;
  logic        r_is_data;
  logic        r_err;
  logic        r_last_data;

  logic        w_dreq;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_misalign;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  // Data wins a tie unless it also won the previous grant.
  assign w_dreq    = dmmRen | dmmWen;
  assign w_grant_d = w_dreq & (~imemRen | ~r_last_data);
  assign w_grant_i = imemRen & ~w_grant_d;

  always_comb begin
    w_misalign = 1'b0;
    unique case (d_fetch)
      c_SZ_HALF: w_misalign = dmmaddr[0];
      c_SZ_BYTE: w_misalign = 1'b0;
      default:   w_misalign = (dmmaddr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = r_wdata;
    unique case (r_size)
      c_SZ_HALF: begin
        w_sel   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      c_SZ_BYTE: begin
        w_sel   = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      default: begin
        w_sel   = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = mem_rdata;
    unique case (r_size)
      c_SZ_HALF: w_load = {16'b0, (r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0])};
      c_SZ_BYTE: w_load = {24'b0, w_shifted[7:0]};
      default:   w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      c_IDLE: begin
        if (w_grant_d) begin
          w_next_state = w_misalign ? c_DONE : c_DACC;
        end else if (w_grant_i) begin
          w_next_state = c_IACC;
        end
      end
      c_IACC, c_DACC: begin
        if (!mem_busy) begin
          w_next_state = c_DONE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    mem_sel   = 4'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    d_err     = 1'b0;
    unique case (r_state)
      c_IACC: begin
        mem_ren  = 1'b1;
        mem_addr = {r_addr[31:2], 2'b00};
        mem_sel  = 4'b1111;
      end
      c_DACC: begin
        mem_ren   = ~r_wr;
        mem_wen   = r_wr;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_sel   = w_sel;
        mem_wdata = w_wdata;
      end
      c_DONE: begin
        i_ready = ~r_is_data;
        d_ready = r_is_data;
        d_err   = r_is_data & r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_addr      <= 32'b0;
      r_wdata     <= 32'b0;
      r_size      <= 2'b0;
      r_wr        <= 1'b0;
      r_is_data   <= 1'b0;
      r_err       <= 1'b0;
      r_last_data <= 1'b0;
      imemload    <= 32'b0;
      dmmload     <= 32'b0;
    end else begin
      if (r_state == c_IDLE) begin
        if (w_grant_d) begin
          r_addr      <= dmmaddr;
          r_wdata     <= dmmstore;
          r_size      <= d_fetch;
          r_wr        <= dmmWen;
          r_is_data   <= 1'b1;
          r_err       <= w_misalign;
          r_last_data <= 1'b1;
          if (w_misalign) begin
            dmmload <= 32'b0;
          end
        end else if (w_grant_i) begin
          r_addr      <= imemaddr;
          r_size      <= c_SZ_WORD;
          r_wr        <= 1'b0;
          r_is_data   <= 1'b0;
          r_err       <= 1'b0;
          r_last_data <= 1'b0;
        end
      end
      if (r_state == c_IACC && !mem_busy) begin
        imemload <= mem_rdata;
      end
      if (r_state == c_DACC && !mem_busy && !r_wr) begin
        dmmload <= w_load;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed vector table plus hand sequences for mem_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nRst;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic [1:0]  d_fetch;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] imemload;
  logic [31:0] dmmload;
  logic        i_ready;
  logic        d_ready;
  logic        d_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .nRst(nRst),
    .imemRen(imemRen), .imemaddr(imemaddr),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .d_fetch(d_fetch), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .imemload(imemload), .dmmload(dmmload),
    .i_ready(i_ready), .d_ready(d_ready), .d_err(d_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fetch;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_err;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs [12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    imemRen  = 1'b0;
    dmmRen   = 1'b0;
    dmmWen   = 1'b0;
    imemaddr = 32'h0;
    dmmaddr  = 32'h0;
    dmmstore = 32'h0;
    d_fetch  = 2'b00;
    mem_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic exp_ren;
    logic exp_wen;
    logic saw_ready;
    logic hold_bad;
    int   n;

    //            fetch rd wr size  addr          store         rdata         sel      e_addr        e_wdata       err  e_load
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h00000100, 32'h0,        32'h00500093, 4'b1111, 32'h00000100, 32'h0,        1'b0, 32'h00500093};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h00002003, 32'h000000AB, 32'h0,        4'b1000, 32'h00002000, 32'hABABABAB, 1'b0, 32'h12345678};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h00002002, 32'h1234CAFE, 32'h0,        4'b1100, 32'h00002000, 32'hCAFECAFE, 1'b0, 32'h12345678};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b00, 32'h00002004, 32'hDEADBEEF, 32'h0,        4'b1111, 32'h00002004, 32'hDEADBEEF, 1'b0, 32'h12345678};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h00002001, 32'h0,        32'h11223344, 4'b0010, 32'h00002000, 32'h0,        1'b0, 32'h00000033};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h00002000, 32'h0,        32'hBEEF1234, 4'b0011, 32'h00002000, 32'h0,        1'b0, 32'h00001234};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h00002008, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h00002008, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h00002001, 32'h0,        32'h99999999, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h00000000};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b11, 32'h0000200C, 32'h0,        32'h01020304, 4'b1111, 32'h0000200C, 32'h0,        1'b0, 32'h01020304};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h00002003, 32'h00005555, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 32'h00000000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h00000103, 32'h0,        32'hAABBCCDD, 4'b1111, 32'h00000100, 32'h0,        1'b0, 32'hAABBCCDD};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h00002003, 32'h0,        32'h11223344, 4'b1000, 32'h00002000, 32'h0,        1'b0, 32'h00000011};

    nRst      = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();
    #12;
    check("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
    check("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_ready", {30'b0, i_ready, d_ready}, 32'd0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_dmmload", dmmload, 32'h0);
    #5 nRst = 1'b1;
    tick();

    // Both requests held: data, fetch, data.
    imemRen = 1'b1; imemaddr = 32'h100;
    dmmRen = 1'b1;  dmmaddr = 32'h2000; d_fetch = 2'b00;
    mem_rdata = 32'h12345678;
    tick();
    check("alt1_addr", mem_addr, 32'h2000);
    check("alt1_ren", {31'b0, mem_ren}, 32'd1);
    tick();
    check("alt1_d_ready", {31'b0, d_ready}, 32'd1);
    tick();
    tick();
    check("alt2_addr", mem_addr, 32'h100);
    tick();
    check("alt2_i_ready", {31'b0, i_ready}, 32'd1);
    tick();
    tick();
    check("alt3_addr", mem_addr, 32'h2000);
    idle_inputs();
    tick();
    check("alt3_d_ready", {31'b0, d_ready}, 32'd1);
    check("alt3_dmmload", dmmload, 32'h12345678);
    tick();

    for (int i = 0; i < 12; i++) begin
      exp_ren = vecs[i].fetch | (vecs[i].rd & ~vecs[i].wr);
      exp_wen = ~vecs[i].fetch & vecs[i].wr;
      imemRen   = vecs[i].fetch;
      imemaddr  = vecs[i].fetch ? vecs[i].addr : 32'h0;
      dmmRen    = vecs[i].rd;
      dmmWen    = vecs[i].wr;
      dmmaddr   = vecs[i].fetch ? 32'h0 : vecs[i].addr;
      dmmstore  = vecs[i].store;
      d_fetch   = vecs[i].size;
      mem_rdata = vecs[i].rdata;
      mem_busy  = 1'b0;
      tick();
      idle_inputs();
      if (vecs[i].e_err) begin
        check($sformatf("v%0d_mis_strobe", i), {30'b0, mem_ren, mem_wen}, 32'd0);
        check($sformatf("v%0d_mis_ready_err", i), {30'b0, d_ready, d_err}, 32'd3);
        check($sformatf("v%0d_mis_load", i), dmmload, vecs[i].e_load);
      end else begin
        check($sformatf("v%0d_strobes", i), {30'b0, mem_ren, mem_wen}, {30'b0, exp_ren, exp_wen});
        check($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
        check($sformatf("v%0d_sel", i), {28'b0, mem_sel}, {28'b0, vecs[i].e_sel});
        if (exp_wen) begin
          check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
        end
        tick();
        check($sformatf("v%0d_ready", i), {29'b0, i_ready, d_ready, d_err},
              {29'b0, vecs[i].fetch, ~vecs[i].fetch, 1'b0});
        check($sformatf("v%0d_done_strobe", i), {30'b0, mem_ren, mem_wen}, 32'd0);
        if (vecs[i].fetch) begin
          check($sformatf("v%0d_imemload", i), imemload, vecs[i].e_load);
        end else begin
          check($sformatf("v%0d_dmmload", i), dmmload, vecs[i].e_load);
        end
      end
      tick();
    end

    // Half load with three wait states; ready lands on the 5th edge after the request edge.
    dmmRen = 1'b1; d_fetch = 2'b01; dmmaddr = 32'h2002;
    mem_rdata = 32'hBEEF1234; mem_busy = 1'b1;
    n = 0;
    hold_bad = 1'b0;
    while (!d_ready && n < 20) begin
      tick();
      n++;
      if (n == 1) dmmRen = 1'b0;
      if (n >= 1 && n <= 4 && (!mem_ren || mem_addr != 32'h2000)) hold_bad = 1'b1;
      if (n == 4) mem_busy = 1'b0;
    end
    check("wait_latency", n, 32'd5);
    check("wait_hold_addr", {31'b0, hold_bad}, 32'd0);
    check("wait_dmmload", dmmload, 32'h0000BEEF);
    idle_inputs();
    tick();

    // Reset during a stalled data write.
    dmmWen = 1'b1; d_fetch = 2'b00; dmmaddr = 32'h3000; dmmstore = 32'h1;
    mem_busy = 1'b1;
    tick();
    dmmWen = 1'b0;
    check("rstmid_wen_before", {31'b0, mem_wen}, 32'd1);
    #2 nRst = 1'b0;
    #1;
    check("rstmid_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
    check("rstmid_addr", mem_addr, 32'h0);
    mem_busy = 1'b0;
    tick();
    tick();
    #3 nRst = 1'b1;
    saw_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (d_ready || i_ready) saw_ready = 1'b1;
    end
    check("rstmid_no_ready", {31'b0, saw_ready}, 32'd0);

    // Previous-grant flag returns to fetch on reset, so a tie goes to data.
    imemRen = 1'b1; imemaddr = 32'h100;
    dmmRen = 1'b1;  dmmaddr = 32'h2000; d_fetch = 2'b00;
    tick();
    idle_inputs();
    check("post_rst_grant_addr", mem_addr, 32'h2000);
    check("post_rst_grant_ren", {31'b0, mem_ren}, 32'd1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
